// File: rtl/acc_drain_if.sv
// Beat stream from the accumulator drain toward the output buffer.
// The drain drives the master side; the downstream sink drives ready.
interface acc_drain_if #(
    parameter int unsigned BEAT_WIDTH = 128
) ();
    logic                  valid;
    logic                  ready;
    logic [BEAT_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/acc_drain.sv
// Accumulator read-side sequencer: walks a wrapping range of entries through the
// combinational read port and streams each vector out as back-to-back beats.
module acc_drain #(
    parameter int unsigned VEC_WIDTH  = 384,
    parameter int unsigned ENTRY_NUM  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(ENTRY_NUM),
    parameter int unsigned BEAT_WIDTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_count,
    input  logic                  i_abort,
    output logic [ADDR_WIDTH-1:0] o_addr_rd,
    input  logic [VEC_WIDTH-1:0]  i_data_rd,
    acc_drain_if.master           out_if,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned BEATS   = VEC_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] vec_t;

    state_t                state_q, state_d;
    vec_t                  vec_q, vec_d;
    logic [BEAT_CW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [BEAT_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  handshake;
    logic                  final_beat;

    assign addr_inc   = (addr_q == ADDR_WIDTH'(ENTRY_NUM - 1)) ? '0 : addr_q + 1'b1;
    assign handshake  = valid_q && out_if.ready;
    assign final_beat = (beat_q == BEAT_CW'(BEATS - 1));

    // State register and all output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            beat_q  <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            beat_q  <= beat_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        beat_d  = beat_q;
        rem_d   = rem_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    rem_d   = i_count;
                    addr_d  = i_base_addr;
                    state_d = (i_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                vec_d   = vec_t'(i_data_rd);
                beat_d  = '0;
                rem_d   = rem_q - 1'b1;
                addr_d  = addr_inc;
                state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (!final_beat) begin
                        beat_d = beat_q + 1'b1;
                    end else if (rem_q != '0) begin
                        // Read port already points at the next entry: no bubble
                        vec_d  = vec_t'(i_data_rd);
                        beat_d = '0;
                        rem_d  = rem_q - 1'b1;
                        addr_d = addr_inc;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        // Outputs are registered from the next-state view so they align with state_q
        valid_d = (state_d == SEND);
        data_d  = valid_d ? vec_d[beat_d] : '0;
        last_d  = valid_d && (beat_d == BEAT_CW'(BEATS - 1)) && (rem_d == '0);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    assign o_addr_rd    = addr_q;
    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;
    assign out_if.last  = last_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: drains, backpressure, wrap, zero count,
// abort/reset mid-drain and start-while-busy.
module tb_acc_drain;

    localparam int unsigned VW    = 384;
    localparam int unsigned EN    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned BW    = 128;
    localparam int unsigned BEATS = 3;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_count;
    logic          i_abort;
    logic          i_ready;
    logic [AW-1:0] o_addr_rd;
    logic [VW-1:0] i_data_rd;
    logic          o_busy;
    logic          o_done;

    logic [VW-1:0] mem [EN];

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    acc_drain_if #(.BEAT_WIDTH(BW)) bif ();

    assign bif.ready = i_ready;
    assign i_data_rd = mem[o_addr_rd];

    acc_drain #(
        .VEC_WIDTH (VW),
        .ENTRY_NUM (EN),
        .ADDR_WIDTH(AW),
        .BEAT_WIDTH(BW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_count    (i_count),
        .i_abort    (i_abort),
        .o_addr_rd  (o_addr_rd),
        .i_data_rd  (i_data_rd),
        .out_if     (bif.master),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Illegal start count must never be presented
    always @(posedge i_clk) begin
        if (i_start) begin
            assert (i_count <= (AW+1)'(EN))
            else begin
                errors++;
                $error("FAIL count_range: observed=%0d expected<=%0d", i_count, EN);
            end
        end
    end

    function automatic logic [BW-1:0] beat_pat(input int e, input int b);
        logic [7:0] ee;
        logic [7:0] bb;
        ee = 8'(e);
        bb = 8'(b);
        return {8{ee, bb}};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Start a drain and check every cycle until idle; optional random ready,
    // abort/reset at a given beat index, and stray starts while busy.
    task automatic run_drain(input int base, input int cnt, input bit rnd,
                             input int abort_at, input bit use_rst, input bit poke);
        int total;
        int idx;
        int cyc;
        int ent;
        bit rdy;
        total = cnt * BEATS;
        idx   = 0;
        cyc   = 0;
        i_base_addr = AW'(base);
        i_count     = (AW+1)'(cnt);
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        if (cnt == 0) begin
            chk("zero_done", BW'(o_done), BW'(1));
            chk("zero_valid", BW'(bif.valid), BW'(0));
            chk("zero_busy", BW'(o_busy), BW'(1));
            step();
            chk("zero_done_end", BW'(o_done), BW'(0));
            chk("zero_idle", BW'(o_busy), BW'(0));
            return;
        end
        chk("load_busy", BW'(o_busy), BW'(1));
        chk("load_valid", BW'(bif.valid), BW'(0));
        chk("load_addr", BW'(o_addr_rd), BW'(base));
        step();
        while (idx < total && cyc < 400) begin
            ent = (base + idx / BEATS) % EN;
            chk("valid", BW'(bif.valid), BW'(1));
            chk("data", bif.data, beat_pat(ent, idx % BEATS));
            chk("last", BW'(bif.last), BW'(idx == total - 1));
            if (idx == abort_at) begin
                i_ready = 1'b1;
                if (use_rst) i_rst = 1'b1;
                else         i_abort = 1'b1;
                step();
                i_rst   = 1'b0;
                i_abort = 1'b0;
                chk("abort_valid", BW'(bif.valid), BW'(0));
                chk("abort_busy", BW'(o_busy), BW'(0));
                chk("abort_done", BW'(o_done), BW'(0));
                chk("abort_last", BW'(bif.last), BW'(0));
                if (use_rst) begin
                    chk("rst_data", bif.data, BW'(0));
                    chk("rst_addr", BW'(o_addr_rd), BW'(0));
                end
                step();
                chk("abort_no_done", BW'(o_done), BW'(0));
                chk("abort_idle", BW'(o_busy), BW'(0));
                return;
            end
            i_start = 1'b0;
            if (poke && idx == 4) begin
                i_start     = 1'b1;
                i_base_addr = AW'(9);
                i_count     = (AW+1)'(1);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_ready = rdy;
            if (rdy) idx++;
            step();
            cyc++;
        end
        i_start = 1'b0;
        chk("beats_done", BW'(idx), BW'(total));
        chk("done_pulse", BW'(o_done), BW'(1));
        chk("done_valid", BW'(bif.valid), BW'(0));
        chk("done_busy", BW'(o_busy), BW'(1));
        if (poke) begin
            i_start     = 1'b1;
            i_base_addr = AW'(3);
            i_count     = (AW+1)'(2);
        end
        step();
        i_start = 1'b0;
        chk("done_once", BW'(o_done), BW'(0));
        chk("idle_busy", BW'(o_busy), BW'(0));
        chk("idle_valid", BW'(bif.valid), BW'(0));
        step();
        chk("stay_idle", BW'(o_busy), BW'(0));
    endtask

    initial begin
        for (int k = 0; k < EN; k++) begin
            mem[k] = {beat_pat(k, 2), beat_pat(k, 1), beat_pat(k, 0)};
        end
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_ready     = 1'b0;
        i_base_addr = '0;
        i_count     = '0;
        step();
        step();
        chk("rst_valid", BW'(bif.valid), BW'(0));
        chk("rst_data", bif.data, BW'(0));
        chk("rst_last", BW'(bif.last), BW'(0));
        chk("rst_busy", BW'(o_busy), BW'(0));
        chk("rst_done", BW'(o_done), BW'(0));
        chk("rst_addr", BW'(o_addr_rd), BW'(0));
        i_rst = 1'b0;

        // Abort in IDLE is ignored
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("idle_abort_busy", BW'(o_busy), BW'(0));
        chk("idle_abort_done", BW'(o_done), BW'(0));

        run_drain(2, 3, 1'b0, -1, 1'b0, 1'b0);
        run_drain(2, 3, 1'b1, -1, 1'b0, 1'b0);
        run_drain(14, 16, 1'b0, -1, 1'b0, 1'b0);
        run_drain(5, 0, 1'b0, -1, 1'b0, 1'b0);
        run_drain(2, 3, 1'b0, 3, 1'b0, 1'b0);
        run_drain(2, 3, 1'b1, -1, 1'b0, 1'b0);
        run_drain(2, 3, 1'b0, 3, 1'b1, 1'b0);
        run_drain(7, 2, 1'b0, -1, 1'b0, 1'b0);
        run_drain(2, 3, 1'b1, -1, 1'b0, 1'b1);

        // Start and abort together in IDLE: start wins
        i_ready     = 1'b1;
        i_start     = 1'b1;
        i_abort     = 1'b1;
        i_base_addr = AW'(15);
        i_count     = (AW+1)'(1);
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start_wins_busy", BW'(o_busy), BW'(1));
        chk("start_wins_addr", BW'(o_addr_rd), BW'(15));
        step();
        chk("start_wins_data", bif.data, beat_pat(15, 0));
        chk("start_wins_last", BW'(bif.last), BW'(0));
        step();
        step();
        chk("start_wins_last2", BW'(bif.last), BW'(1));
        step();
        chk("start_wins_done", BW'(o_done), BW'(1));
        step();
        chk("start_wins_idle", BW'(o_busy), BW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
